mul_iter_unit: RTL and testbench
================================

Name: mul_iter_unit

Overview:
Iterative shift-add multiplier in the execute stage, directly downstream of the register file. It consumes the two read-port values plus an accumulate operand and implements MUL and MLA (32x32 -> low 32 bits). It returns the result through a one-cycle write-back request that feeds the register file write port (we3/wa3/wd3). While busy it presents a pending-destination tag so the hazard unit can stall dependent instructions.

Parameters:
WIDTH, 32, operand/result width; also the number of iteration cycles
AW, 4, register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  issue request; accepted only in IDLE
mla  in  1  1 = accumulate (result = acc_in + a*b), 0 = plain multiply
set_flags  in  1  update N/Z on completion
dst  in  AW  destination register
op_a  in  WIDTH  multiplicand (Rm, from rd1)
op_b  in  WIDTH  multiplier (Rs, from rd2)
acc_in  in  WIDTH  accumulate operand (Rn)
flush  in  1  synchronous abort of the in-flight operation
busy  out  1  high in RUN and DONE
pend_dst  out  AW  latched dst while busy, else 0
wb_we  out  1  one-cycle write-back strobe
wb_addr  out  AW  write-back destination
wb_data  out  WIDTH  result
flag_we  out  1  one-cycle N/Z update strobe
flag_n  out  1  result[WIDTH-1]
flag_z  out  1  result == 0
done  out  1  one-cycle completion pulse, asserted even when wb_we is suppressed

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE; all outputs 0; internal registers cleared. Reset overrides every other input. Reset mid-operation discards the operation with no wb_we, flag_we or done.
- FSM IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
- IDLE: if start=1 and flush=0 at edge k, latch a=op_a, b=op_b, dst, set_flags, and acc = mla ? acc_in : 0. Set cnt=0 and go to RUN. busy=1 from cycle k+1.
- RUN, one multiplier bit per cycle, LSB first: if b[0], acc += a (mod 2^WIDTH); a <<= 1; b >>= 1; cnt++. On the edge where cnt==WIDTH-1, go to DONE. There is no early termination, so latency is fixed.
- DONE (cycle k+WIDTH+1): done=1, wb_addr=dst, wb_data=acc.
  - wb_we=1 unless dst==15. A PC destination is suppressed: wb_we=0, done still pulses.
  - If set_flags: flag_we=1, flag_n=acc[WIDTH-1], flag_z=(acc==0). C and V are not produced.
  - The next edge returns to IDLE. busy=0 and strobes=0 from cycle k+WIDTH+2.
- Strobes (wb_we, flag_we, done) are high for exactly one cycle. wb_addr, wb_data and flags hold their last values while idle.
- start while busy (RUN or DONE) is ignored and not queued. The issuer must wait for busy=0, so back-to-back issue is possible at the earliest in the cycle busy drops.
- flush=1 at any edge forces IDLE on that edge: busy=0 and no strobes.
  - flush in DONE cancels the strobes only if sampled before DONE is entered. The DONE-cycle strobes are already registered and are not retracted.
  - flush together with start in IDLE: flush wins and start is dropped.
- pend_dst = latched dst while busy, else 0. The hazard unit compares it with ra1/ra2.
- Arithmetic is unsigned modulo 2^WIDTH. The low word is identical for signed operands.

Test Plan:
- MUL 3*5, dst=2, start at edge 0 -> busy cycles 1..33; cycle 33: wb_we=1, wb_addr=2, wb_data=0x0000000F, done=1; cycle 34: busy=0.
- MLA 0xFFFFFFFF*2 + 1, set_flags=1, dst=4 -> cycle 33: wb_data=0xFFFFFFFF, flag_we=1, flag_n=1, flag_z=0.
- MUL 0x00010000*0x00010000, set_flags=1 -> wb_data=0x00000000, flag_z=1, flag_n=0 (truncation).
- Issue 7*9 dst=1; assert start with 2*2 dst=3 at cycle 10 -> only one write-back (dst=1, 0x3F) at cycle 33; nothing for dst=3.
- flush at cycle 12 of an operation -> busy=0 at cycle 13; no wb_we, flag_we or done. Reset at cycle 20 of a new operation -> all outputs 0, no strobes.
- dst=15, 4*4 -> cycle 33: done=1, wb_we=0; pend_dst=15 during cycles 1..33.

Source files
------------

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative shift-add MUL/MLA (low word) with register-file write-back and N/Z flag update
//   in : clk, reset, start, mla, set_flags, dst, op_a, op_b, acc_in, flush
//   out: busy, pend_dst, wb_we, wb_addr, wb_data, flag_we, flag_n, flag_z, done
module mul_iter_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mla,
  input  logic             set_flags,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             flush,
  output logic             busy,
  output logic [AW-1:0]    pend_dst,
  output logic             wb_we,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_we,
  output logic             flag_n,
  output logic             flag_z,
  output logic             done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    dst_q;
  logic             sf_q;
  logic             busy_q, wb_we_q, flag_we_q, flag_n_q, flag_z_q, done_q;
  logic [AW-1:0]    pend_q, wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  assign acc_d = b_q[0] ? acc_q + a_q : acc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dst_q     <= '0;
      sf_q      <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_we_q <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wb_we_q   <= 1'b0;
      flag_we_q <= 1'b0;
      done_q    <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        pend_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            acc_q   <= mla ? acc_in : '0;
            dst_q   <= dst;
            sf_q    <= set_flags;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            pend_q  <= dst;
            state_q <= RUN;
          end
          RUN: begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            // Result strobes are registered on the last iteration edge so they appear in the DONE cycle.
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              wb_we_q   <= dst_q != AW'(15);
              wb_addr_q <= dst_q;
              wb_data_q <= acc_d;
              if (sf_q) begin
                flag_we_q <= 1'b1;
                flag_n_q  <= acc_d[WIDTH-1];
                flag_z_q  <= acc_d == '0;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pend_q  <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign busy     = busy_q;
  assign pend_dst = pend_q;
  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flag_we  = flag_we_q;
  assign flag_n   = flag_n_q;
  assign flag_z   = flag_z_q;
  assign done     = done_q;
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: directed vector and corner-sequence bench for mul_iter_unit
module tb_mul_iter_unit;
  logic        clk = 0, reset = 1, start = 0, mla = 0, set_flags = 0, flush = 0;
  logic [3:0]  dst = 0;
  logic [31:0] op_a = 0, op_b = 0, acc_in = 0;
  logic        busy, wb_we, flag_we, flag_n, flag_z, done;
  logic [3:0]  pend_dst, wb_addr;
  logic [31:0] wb_data;
  int tests = 0, fails = 0;

  mul_iter_unit dut (
    .clk(clk), .reset(reset), .start(start), .mla(mla), .set_flags(set_flags),
    .dst(dst), .op_a(op_a), .op_b(op_b), .acc_in(acc_in), .flush(flush),
    .busy(busy), .pend_dst(pend_dst), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, acc;
    logic        mla, sf;
    logic [3:0]  dst;
    logic [31:0] exp_data;
    logic        exp_we, exp_n, exp_z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                       input logic m, input logic sf, input logic [3:0] d);
    op_a = a; op_b = b; acc_in = acc; mla = m; set_flags = sf; dst = d; start = 1;
  endtask

  // Called just after a negedge with the unit idle; returns at the negedge of cycle 34.
  task automatic run_vec(input vec_t v);
    issue(v.a, v.b, v.acc, v.mla, v.sf, v.dst);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 0;
      chk("busy", 32'(busy), 32'(c <= 33));
      chk("pend_dst", 32'(pend_dst), c <= 33 ? 32'(v.dst) : 32'd0);
      if (c < 33 || c == 34) begin
        chk("done_idle", 32'(done), 0);
        chk("wb_we_idle", 32'(wb_we), 0);
        chk("flag_we_idle", 32'(flag_we), 0);
      end else begin
        chk("done", 32'(done), 1);
        chk("wb_we", 32'(wb_we), 32'(v.exp_we));
        chk("wb_addr", 32'(wb_addr), 32'(v.dst));
        chk("wb_data", wb_data, v.exp_data);
        chk("flag_we", 32'(flag_we), 32'(v.sf));
        if (v.sf) begin
          chk("flag_n", 32'(flag_n), 32'(v.exp_n));
          chk("flag_z", 32'(flag_z), 32'(v.exp_z));
        end
      end
    end
  endtask

  task automatic quiet(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = 0;
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_strobes"}, {29'd0, wb_we, flag_we, done}, 0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'd2, 32'h0000000F, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd2, 32'd1, 1'b1, 1'b1, 4'd4, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b1, 4'd5, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 4'd15, 32'h00000010, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'd7, 32'd6, 32'd100, 1'b1, 1'b1, 4'd7, 32'h0000008E, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 4'd3, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'd2, 32'd3, 32'd1000, 1'b0, 1'b0, 4'd6, 32'h00000006, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'd0, 32'h12345678, 32'd0, 1'b0, 1'b1, 4'd8, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFFFFFE, 32'd3, 32'd0, 1'b0, 1'b1, 4'd9, 32'hFFFFFFFA, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_pend", 32'(pend_dst), 0);
    chk("reset_strobes", {29'd0, wb_we, flag_we, done}, 0);
    chk("reset_wb", {wb_addr, wb_data[27:0]}, 0);
    chk("reset_flags", {30'd0, flag_n, flag_z}, 0);

    // Each vector issues in the cycle the previous one drops busy (back-to-back).
    foreach (vecs[i]) run_vec(vecs[i]);
    quiet(1, "after_vecs");

    // start while busy is ignored: only 7*9 -> dst 1 is written back.
    issue(32'd7, 32'd9, 32'd0, 1'b0, 1'b0, 4'd1);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 0;
      if (c == 10) issue(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 4'd3);
      if (c == 33) begin
        chk("ign_done", 32'(done), 1);
        chk("ign_we", 32'(wb_we), 1);
        chk("ign_addr", 32'(wb_addr), 1);
        chk("ign_data", wb_data, 32'h3F);
      end else begin
        chk("ign_no_wb", {29'd0, wb_we, flag_we, done}, 0);
        chk("ign_busy", 32'(busy), 32'(c <= 33));
        if (c <= 33) chk("ign_pend", 32'(pend_dst), 1);
      end
    end
    quiet(40, "ign_queued");

    // flush sampled at edge 12 aborts the operation.
    issue(32'd11, 32'd13, 32'd0, 1'b0, 1'b1, 4'd2);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 0;
      chk("fl_busy_pre", 32'(busy), 1);
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fl_busy", 32'(busy), 0);
    chk("fl_pend", 32'(pend_dst), 0);
    chk("fl_wb_hold", wb_data, 32'h3F);
    quiet(30, "fl_after");

    // flush on the edge that would enter DONE suppresses all strobes.
    issue(32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 4'd2);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      start = 0;
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fl32_busy", 32'(busy), 0);
    chk("fl32_strobes", {29'd0, wb_we, flag_we, done}, 0);
    quiet(3, "fl32_after");

    // flush in the DONE cycle does not retract the already-visible strobes.
    issue(32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 4'd2);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 0;
    end
    chk("fldone_done", 32'(done), 1);
    chk("fldone_data", wb_data, 32'd25);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fldone_busy", 32'(busy), 0);
    quiet(3, "fldone_after");

    // flush together with start in IDLE drops the start.
    issue(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'd5);
    flush = 1;
    @(negedge clk);
    flush = 0;
    start = 0;
    chk("flst_busy", 32'(busy), 0);
    quiet(40, "flst_after");

    // reset at cycle 20 of an operation clears everything.
    issue(32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 4'd6);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 0;
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pend_dst), 0);
    chk("rst_wb", {wb_addr, wb_data[27:0]}, 0);
    chk("rst_flags", {29'd0, flag_we, flag_n, flag_z}, 0);
    quiet(40, "rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
